// File: rtl/hack_cpu_pkg.sv
// Shared definitions for the Hack CPU core: instruction field positions,
// FSM state encoding, ALU control bundle and the jump-condition helper.
package hack_cpu_pkg;

  localparam int PC_W_DEF  = 15;
  localparam int CNT_W_DEF = 16;

  localparam int IS_C    = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int J_LT    = 2;
  localparam int J_EQ    = 1;
  localparam int J_GT    = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  function automatic logic jump_taken(
    input logic lt,
    input logic eq,
    input logic gt,
    input logic zr,
    input logic ng
  );
    return (lt & ng) | (eq & zr) | (gt & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_cpu_alu16.sv
// Hack 16-bit ALU: optional zero/negate of each operand, add or and,
// optional output negate.  Ports: x_i, y_i operands, six control bits,
// out_o result, zr_o (result is zero), ng_o (result is negative).
module alu16 (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        zx_i,
  input  logic        nx_i,
  input  logic        zy_i,
  input  logic        ny_i,
  input  logic        f_i,
  input  logic        no_i,
  output logic [15:0] out_o,
  output logic        zr_o,
  output logic        ng_o
);

  logic [15:0] x0;
  logic [15:0] x1;
  logic [15:0] y0;
  logic [15:0] y1;
  logic [15:0] f0;

  always_comb begin
    x0    = zx_i ? 16'h0000 : x_i;
    x1    = nx_i ? ~x0 : x0;
    y0    = zy_i ? 16'h0000 : y_i;
    y1    = ny_i ? ~y0 : y0;
    f0    = f_i ? (x1 + y1) : (x1 & y1);
    out_o = no_i ? ~f0 : f0;
    zr_o  = (out_o == 16'h0000);
    ng_o  = out_o[15];
  end

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: decodes A/C instructions, holds A, D and PC, drives the
// ALU, evaluates jumps and stalls on fetch/memory valid/ready handshakes.
// Ports: clk, reset (sync, active high), instruction/ins_valid (fetch),
// in_m/mem_ready (data memory), out_m/write_m/address_m (memory write),
// pc (next fetch address), halted (sticky halt-loop flag), instret.
module hack_cpu
  import hack_cpu_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instruction,
  input  logic             ins_valid,
  input  logic [15:0]      in_m,
  input  logic             mem_ready,
  output logic [15:0]      out_m,
  output logic             write_m,
  output logic [PC_W-1:0]  address_m,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [15:0]      a_q;
  logic [15:0]      a_d;
  logic [15:0]      d_q;
  logic [15:0]      d_d;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             prev_a_q;
  logic             prev_a_d;
  logic             halted_q;
  logic             halted_d;
  state_e           state_q;
  state_e           state_d;

  logic            is_c;
  logic            a_sel;
  logic            dest_a;
  logic            dest_d;
  logic            dest_m;
  logic            uses_m;
  logic            run;
  logic            commit;
  logic            taken;
  logic            halt_hit;
  logic [PC_W-1:0] target;
  alu_ctrl_t       ctrl;
  logic [15:0]     alu_y;
  logic [15:0]     alu_out;
  logic            zr;
  logic            ng;

  assign is_c   = instruction[IS_C];
  assign a_sel  = is_c & instruction[A_BIT];
  assign dest_a = is_c & instruction[DEST_A];
  assign dest_d = is_c & instruction[DEST_D];
  assign dest_m = is_c & instruction[DEST_M];
  assign ctrl   = alu_ctrl_t'(instruction[COMP_HI:COMP_LO]);
  assign alu_y  = a_sel ? in_m : a_q;

  alu16 u_alu (
    .x_i  (d_q),
    .y_i  (alu_y),
    .zx_i (ctrl.zx),
    .nx_i (ctrl.nx),
    .zy_i (ctrl.zy),
    .ny_i (ctrl.ny),
    .f_i  (ctrl.f),
    .no_i (ctrl.no),
    .out_o(alu_out),
    .zr_o (zr),
    .ng_o (ng)
  );

  assign run    = (state_q == ST_RUN);
  assign uses_m = a_sel | dest_m;
  assign commit = run & ins_valid & (~uses_m | mem_ready);

  assign taken = is_c & jump_taken(instruction[J_LT],
                                   instruction[J_EQ],
                                   instruction[J_GT],
                                   zr, ng);

  // Jump target is always the pre-edge A, even if destA rewrites it.
  assign target = a_q[PC_W-1:0];

  // "@X ; 0;JMP" where X is the address of the @X itself.
  assign halt_hit = taken & prev_a_q & (target == (pc_q - PC_ONE));

  always_comb begin
    a_d      = a_q;
    d_d      = d_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    prev_a_d = prev_a_q;
    halted_d = halted_q;
    state_d  = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (commit) begin
          cnt_d    = cnt_q + CNT_ONE;
          prev_a_d = ~is_c;
          pc_d     = taken ? target : (pc_q + PC_ONE);
          if (!is_c) begin
            a_d = {1'b0, instruction[14:0]};
          end else if (dest_a) begin
            a_d = alu_out;
          end
          if (dest_d) begin
            d_d = alu_out;
          end
          if (halt_hit) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      d_q      <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      prev_a_q <= 1'b0;
      halted_q <= 1'b0;
      state_q  <= ST_RUN;
    end else begin
      a_q      <= a_d;
      d_q      <= d_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      prev_a_q <= prev_a_d;
      halted_q <= halted_d;
      state_q  <= state_d;
    end
  end

  // Held high across a memory stall; memory commits on write_m & mem_ready.
  assign write_m   = ~reset & run & ins_valid & dest_m;
  assign out_m     = alu_out;
  assign address_m = a_q[PC_W-1:0];
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign instret   = cnt_q;

endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: directed scenarios with literal
// expectations plus randomized traffic against an instruction-level model.
module tb_hack_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instruction = 16'hFFFF;
  logic        ins_valid = 1'b1;
  logic [15:0] in_m = 16'h0000;
  logic        mem_ready = 1'b1;
  logic [15:0] out_m;
  logic        write_m;
  logic [14:0] address_m;
  logic [14:0] pc;
  logic        halted;
  logic [15:0] instret;

  hack_cpu #(.PC_W(15), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .ins_valid  (ins_valid),
    .in_m       (in_m),
    .mem_ready  (mem_ready),
    .out_m      (out_m),
    .write_m    (write_m),
    .address_m  (address_m),
    .pc         (pc),
    .halted     (halted),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-level reference model.
  logic [15:0] mA = 0;
  logic [15:0] mD = 0;
  logic [14:0] mpc = 0;
  logic [15:0] minst = 0;
  bit          mhalt = 0;
  bit          mprev = 0;

  function automatic logic [15:0] m_alu(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic [5:0] c);
    logic [15:0] r;
    if (c[5]) x = 16'h0000;
    if (c[4]) x = ~x;
    if (c[3]) y = 16'h0000;
    if (c[2]) y = ~y;
    r = c[1] ? x + y : x & y;
    if (c[0]) r = ~r;
    return r;
  endfunction

  always @(posedge clk) begin
    logic [15:0] r;
    logic [14:0] tgt;
    bit tk;
    if (reset) begin
      mA = 0; mD = 0; mpc = 0; minst = 0; mhalt = 0; mprev = 0;
    end else if (!mhalt && ins_valid) begin
      if (!instruction[15]) begin
        mA = {1'b0, instruction[14:0]};
        mpc = mpc + 15'd1;
        mprev = 1;
        minst = minst + 16'd1;
      end else if (!((instruction[12] || instruction[3]) && !mem_ready)) begin
        r = m_alu(mD, instruction[12] ? in_m : mA, instruction[11:6]);
        tk = (instruction[2] && $signed(r) < 0) ||
             (instruction[1] && r == 16'h0000) ||
             (instruction[0] && $signed(r) > 0);
        tgt = mA[14:0];
        if (tk && mprev && tgt == mpc - 15'd1) mhalt = 1;
        mpc = tk ? tgt : mpc + 15'd1;
        if (instruction[5]) mA = r;
        if (instruction[4]) mD = r;
        mprev = 0;
        minst = minst + 16'd1;
      end
    end
  end

  // Per-cycle compare; inputs are stable from posedge+1 to next posedge.
  always @(negedge clk) begin
    logic ewm;
    if (chk_en) begin
      ewm = !reset && !mhalt && ins_valid && instruction[15] && instruction[3];
      chk("m_write_m", {31'd0, write_m}, {31'd0, ewm});
      chk("m_pc", {17'd0, pc}, {17'd0, mpc});
      chk("m_address_m", {17'd0, address_m}, {17'd0, mA[14:0]});
      chk("m_halted", {31'd0, halted}, {31'd0, mhalt});
      chk("m_instret", {16'd0, instret}, {16'd0, minst});
      if (ewm)
        chk("m_out_m", {16'd0, out_m},
            {16'd0, m_alu(mD, instruction[12] ? in_m : mA, instruction[11:6])});
    end
  end

  task automatic cyc(input logic [15:0] ins, input logic v,
                     input logic rdy, input logic [15:0] im);
    @(posedge clk);
    #1;
    reset = 1'b0;
    instruction = ins;
    ins_valid = v;
    mem_ready = rdy;
    in_m = im;
  endtask

  task automatic idle();
    cyc(16'hFFFF, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] cnt_snap;
    logic [14:0] x;

    // Reset with garbage and ins_valid high.
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_pc", {17'd0, pc}, 32'd0);
    chk("rst_addr", {17'd0, address_m}, 32'd0);
    chk("rst_write_m", {31'd0, write_m}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_instret", {16'd0, instret}, 32'd0);

    // @100, D=A, @3, D=D+A
    cyc(16'h0064, 1, 1, 0);
    cyc(16'hEC10, 1, 1, 0);
    cyc(16'h0003, 1, 1, 0);
    cyc(16'hE090, 1, 1, 0);
    idle();
    @(negedge clk);
    chk("stream_pc", {17'd0, pc}, 32'd4);
    chk("stream_instret", {16'd0, instret}, 32'd4);

    // @7, M=D with a 3-cycle memory stall.
    cyc(16'h0007, 1, 1, 0);
    cyc(16'hE308, 1, 0, 16'h1234);
    @(negedge clk);
    chk("stall_write_m", {31'd0, write_m}, 32'd1);
    chk("stall_addr", {17'd0, address_m}, 32'd7);
    chk("stall_out_m", {16'd0, out_m}, 32'd103);
    chk("stall_pc", {17'd0, pc}, 32'd5);
    chk("stall_instret", {16'd0, instret}, 32'd5);
    cyc(16'hE308, 1, 0, 16'h5555);
    cyc(16'hE308, 1, 0, 16'hAAAA);
    @(negedge clk);
    chk("stall3_out_m", {16'd0, out_m}, 32'd103);
    cyc(16'hE308, 1, 1, 16'h0000);
    idle();
    @(negedge clk);
    chk("stall_done_pc", {17'd0, pc}, 32'd6);
    chk("stall_done_instret", {16'd0, instret}, 32'd6);
    chk("stall_done_write_m", {31'd0, write_m}, 32'd0);

    // D=-1, @20, D;JLT -> taken
    cyc(16'hEE90, 1, 1, 0);
    cyc(16'h0014, 1, 1, 0);
    cyc(16'hE304, 1, 1, 0);
    idle();
    @(negedge clk);
    chk("jlt_taken_pc", {17'd0, pc}, 32'd20);

    // D=1, @20, D;JLT -> not taken
    cyc(16'hEFD0, 1, 1, 0);
    cyc(16'h0014, 1, 1, 0);
    cyc(16'hE304, 1, 1, 0);
    idle();
    @(negedge clk);
    chk("jlt_not_taken_pc", {17'd0, pc}, 32'd23);
    cnt_snap = instret;
    repeat (5) cyc(16'hE308, 0, 1, 16'h00FF);
    @(negedge clk);
    chk("novalid_pc", {17'd0, pc}, 32'd23);
    chk("novalid_instret", {16'd0, instret}, {16'd0, cnt_snap});

    // Halt loop: jump to 5, then @5 at 5 and 0;JMP at 6.
    do_reset();
    cyc(16'h0005, 1, 1, 0);
    cyc(16'hEA87, 1, 1, 0);
    cyc(16'h0005, 1, 1, 0);
    cyc(16'hEA87, 1, 1, 0);
    idle();
    @(negedge clk);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", {17'd0, pc}, 32'd5);
    repeat (20)
      cyc({1'b1, 15'($urandom)}, 1'($urandom), 1'($urandom), 16'($urandom));
    cyc(16'hE308, 1, 1, 0);
    @(negedge clk);
    chk("halt_write_m", {31'd0, write_m}, 32'd0);
    chk("halt_hold_pc", {17'd0, pc}, 32'd5);
    chk("halt_hold_instret", {16'd0, instret}, 32'd4);
    do_reset();
    idle();
    @(negedge clk);
    chk("unhalt_flag", {31'd0, halted}, 32'd0);
    chk("unhalt_pc", {17'd0, pc}, 32'd0);

    // Reset arriving mid-stall.
    cyc(16'h0009, 1, 1, 0);
    cyc(16'hE308, 1, 0, 0);
    @(negedge clk);
    chk("mid_write_m", {31'd0, write_m}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_write_m", {31'd0, write_m}, 32'd0);
    @(negedge clk);
    chk("mid_rst_pc", {17'd0, pc}, 32'd0);
    chk("mid_rst_addr", {17'd0, address_m}, 32'd0);
    chk("mid_rst_instret", {16'd0, instret}, 32'd0);

    // Randomized traffic with occasional halt-loop injection and resets.
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 250) begin
        x = 15'($urandom_range(0, 60));
        cyc({1'b0, x}, 1, 1, 0);
        cyc(16'hEA87, 1, 1, 0);
        cyc({1'b0, x}, 1, 1, 0);
        cyc(16'hEA87, 1, 1, 0);
      end else if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 1) == 0) begin
        cyc({1'b0, 15'($urandom_range(0, 63))},
            $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom));
      end else begin
        cyc({3'b111, 13'($urandom)},
            $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom));
      end
    end

    idle();
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
